wifi_tx_conv_encoder: RTL and testbench



---
 rtl/wifi_tx_conv_encoder_pkg.sv | 28 ++
 rtl/wifi_tx_conv_core.sv | 17 +
 rtl/wifi_tx_conv_encoder.sv | 136 +++++++++++++
 tb/tb_wifi_tx_conv_encoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/wifi_tx_conv_encoder_pkg.sv
// Shared WIFI TX encoder definitions: FSM state encoding, default generator
// polynomials and tail length, plus the parity helper used by the encoder core.
package wifi_tx_conv_encoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EMIT_A = 3'd1,
    ST_EMIT_B = 3'd2,
    ST_TAIL_A = 3'd3,
    ST_TAIL_B = 3'd4
  } state_e;

  localparam logic [6:0]  G0_DEFAULT        = 7'o133;
  localparam logic [6:0]  G1_DEFAULT        = 7'o171;
  localparam int unsigned TAIL_BITS_DEFAULT = 6;

  // Generator bit 6 taps the current input, bit (5-k) taps history s[k].
  function automatic logic conv_parity(input logic d, input logic [5:0] s,
                                       input logic [6:0] g);
    logic p;
    p = d & g[6];
    for (int k = 0; k < 6; k++) begin
      p = p ^ (s[k] & g[5-k]);
    end
    return p;
  endfunction

endpackage

// File: rtl/wifi_tx_conv_core.sv
// Pure combinational K=7 rate-1/2 encoder step: (d, history) -> (A, B).
module wifi_tx_conv_core
  import wifi_tx_conv_encoder_pkg::*;
#(
  parameter logic [6:0] G0 = G0_DEFAULT,
  parameter logic [6:0] G1 = G1_DEFAULT
) (
  input  logic       d,
  input  logic [5:0] s,
  output logic       a,
  output logic       b
);

  assign a = conv_parity(d, s, G0);
  assign b = conv_parity(d, s, G1);

endmodule

// File: rtl/wifi_tx_conv_encoder.sv
// Serial convolutional encoder: emits A,B per accepted bit as one gap-free
// valid_out burst, followed by zero tail bits that terminate the trellis.
module wifi_tx_conv_encoder
  import wifi_tx_conv_encoder_pkg::*;
#(
  parameter int unsigned TAIL_BITS = TAIL_BITS_DEFAULT,
  parameter logic [6:0]  G0        = G0_DEFAULT,
  parameter logic [6:0]  G1        = G1_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic valid_in,
  input  logic data_in,
  output logic ready,
  output logic valid_out,
  output logic data_out,
  output logic finished
);

  localparam logic [5:0] TAIL_LAST = 6'(TAIL_BITS);
  localparam bit         HAS_TAIL  = (TAIL_BITS != 0);

  state_e     state_q;
  logic [5:0] shift_q;
  logic [5:0] shift_d;
  logic [5:0] tail_cnt_q;
  logic       held_b_q;
  logic       valid_q;
  logic       data_q;
  logic       finished_q;

  logic       enc_bit;
  logic [5:0] enc_hist;
  logic       enc_a;
  logic       enc_b;

  // A new frame always encodes from zero history; tail steps encode zeros.
  always_comb begin
    enc_bit  = data_in;
    enc_hist = shift_q;
    case (state_q)
      ST_IDLE:   enc_hist = '0;
      ST_EMIT_B: if (!valid_in) enc_bit = 1'b0;
      ST_TAIL_B: enc_bit = 1'b0;
      default:   ;
    endcase
    shift_d = {enc_hist[4:0], enc_bit};
  end

  wifi_tx_conv_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .d (enc_bit),
    .s (enc_hist),
    .a (enc_a),
    .b (enc_b)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      tail_cnt_q <= '0;
      held_b_q   <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 1'b0;
      finished_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_in && enable) begin
            shift_q    <= shift_d;
            data_q     <= enc_a;
            held_b_q   <= enc_b;
            valid_q    <= 1'b1;
            finished_q <= 1'b0;
            state_q    <= ST_EMIT_A;
          end
        end
        ST_EMIT_A: begin
          data_q  <= held_b_q;
          state_q <= ST_EMIT_B;
        end
        ST_EMIT_B: begin
          if (valid_in) begin
            shift_q  <= shift_d;
            data_q   <= enc_a;
            held_b_q <= enc_b;
            state_q  <= ST_EMIT_A;
          end else if (HAS_TAIL) begin
            shift_q    <= shift_d;
            data_q     <= enc_a;
            held_b_q   <= enc_b;
            tail_cnt_q <= 6'd1;
            state_q    <= ST_TAIL_A;
          end else begin
            valid_q    <= 1'b0;
            data_q     <= 1'b0;
            finished_q <= 1'b1;
            shift_q    <= '0;
            state_q    <= ST_IDLE;
          end
        end
        ST_TAIL_A: begin
          data_q  <= held_b_q;
          state_q <= ST_TAIL_B;
        end
        ST_TAIL_B: begin
          if (tail_cnt_q < TAIL_LAST) begin
            shift_q    <= shift_d;
            data_q     <= enc_a;
            held_b_q   <= enc_b;
            tail_cnt_q <= tail_cnt_q + 6'd1;
            state_q    <= ST_TAIL_A;
          end else begin
            valid_q    <= 1'b0;
            data_q     <= 1'b0;
            finished_q <= 1'b1;
            shift_q    <= '0;
            tail_cnt_q <= '0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready     = (state_q == ST_IDLE) || (state_q == ST_EMIT_B);
  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign finished  = finished_q;

endmodule

// File: tb/tb_wifi_tx_conv_encoder.sv
// Directed bench for wifi_tx_conv_encoder: default build plus a TAIL_BITS=0 build.
module tb_wifi_tx_conv_encoder;

  logic clk;
  logic reset;
  logic enable;
  logic valid_in;
  logic data_in;
  logic ready, valid_out, data_out, finished;
  logic ready0, valid_out0, data_out0, finished0;

  int errors = 0;
  int checks = 0;

  wifi_tx_conv_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready     (ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .finished  (finished)
  );

  wifi_tx_conv_encoder #(.TAIL_BITS(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready     (ready0),
    .valid_out (valid_out0),
    .data_out  (data_out0),
    .finished  (finished0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected coded stream from a string of '0'/'1', first character = first bit.
  function automatic logic [127:0] pat(input string s);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < s.len(); i++) p[i] = (s[i] == "1");
    return p;
  endfunction

  // Reference encoder: h1..h6 hold the bits 1..6 steps in the past.
  function automatic logic [127:0] ref_enc(input logic [63:0] bits, input int n, input int tail);
    logic [127:0] r;
    logic d, h1, h2, h3, h4, h5, h6;
    r = '0;
    {h1, h2, h3, h4, h5, h6} = '0;
    for (int i = 0; i < n + tail; i++) begin
      d = (i < n) ? bits[i] : 1'b0;
      r[2*i]   = d ^ h2 ^ h3 ^ h5 ^ h6;
      r[2*i+1] = d ^ h1 ^ h2 ^ h3 ^ h6;
      h6 = h5; h5 = h4; h4 = h3; h3 = h2; h2 = h1; h1 = d;
    end
    return r;
  endfunction

  task automatic run_frame(input logic [63:0] bits, input int n, input bit hold, input bit use0,
                           output logic [127:0] got, output int cnt, output int lat,
                           output int rdy_hi, output bit fin_ok, output bit done);
    int idx, acc_cyc, first_v;
    bit started;
    logic vo, dout, rdy, fin;
    got = '0; cnt = 0; idx = 0; acc_cyc = -1; first_v = -1;
    started = 0; done = 0; rdy_hi = 0; fin_ok = 1;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      vo   = use0 ? valid_out0 : valid_out;
      dout = use0 ? data_out0  : data_out;
      rdy  = use0 ? ready0     : ready;
      fin  = use0 ? finished0  : finished;
      if (vo) begin
        if (!started) first_v = cyc;
        started = 1;
        got[cnt] = dout;
        cnt++;
        if (fin) fin_ok = 0;
        if (rdy) rdy_hi++;
      end else if (started) begin
        done = 1;
        if (!fin) fin_ok = 0;
      end
      if (!done && idx < n && (hold || rdy)) begin
        enable   = 1'b1;
        valid_in = 1'b1;
        data_in  = bits[idx];
        if (rdy) begin
          if (acc_cyc < 0) acc_cyc = cyc;
          idx++;
        end
      end else begin
        valid_in = 1'b0;
        data_in  = 1'b0;
      end
    end
    valid_in = 1'b0;
    enable   = 1'b0;
    lat = first_v - acc_cyc;
  endtask

  initial begin
    logic [127:0] got;
    int cnt, lat, rdy_hi, seen;
    bit fin_ok, done;

    reset = 1'b1; enable = 1'b0; valid_in = 1'b0; data_in = 1'b0;
    #1 reset = 1'b0;
    #3;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_data_out", data_out, 1'b0);
    chk("rst_finished", finished, 1'b1);
    chk("rst_ready", ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Impulse response
    run_frame(64'h1, 1, 0, 0, got, cnt, lat, rdy_hi, fin_ok, done);
    chk("imp_done", done, 1'b1);
    chk("imp_len", cnt, 14);
    chk("imp_bits", got, pat("11011111001011"));
    chk("imp_latency", lat, 1);
    chk("imp_finished", fin_ok, 1'b1);
    chk("imp_ready_hi", rdy_hi, 1);

    // 24 zero bits
    run_frame(64'h0, 24, 0, 0, got, cnt, lat, rdy_hi, fin_ok, done);
    chk("zero_done", done, 1'b1);
    chk("zero_len", cnt, 60);
    chk("zero_bits", got, 128'h0);
    chk("zero_latency", lat, 1);
    chk("zero_finished", fin_ok, 1'b1);

    // valid_in held high over a 24-bit stream
    run_frame(64'hB35EC9, 24, 1, 0, got, cnt, lat, rdy_hi, fin_ok, done);
    chk("hold_done", done, 1'b1);
    chk("hold_len", cnt, 60);
    chk("hold_bits", got, ref_enc(64'hB35EC9, 24, 6));
    chk("hold_ready_hi", rdy_hi, 24);
    chk("hold_finished", fin_ok, 1'b1);

    // enable low in IDLE blocks the start
    @(negedge clk);
    enable = 1'b0; valid_in = 1'b1; data_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en0_ready", ready, 1'b1);
      chk("en0_valid_out", valid_out, 1'b0);
      chk("en0_finished", finished, 1'b1);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("en1_valid_out", valid_out, 1'b1);
    chk("en1_data_out", data_out, 1'b1);
    chk("en1_finished", finished, 1'b0);
    valid_in = 1'b0; enable = 1'b0; data_in = 1'b0;
    seen = 1;
    for (int i = 0; i < 40 && valid_out; i++) begin
      @(negedge clk);
      if (valid_out) seen++;
    end
    chk("en_len", seen, 14);
    chk("en_end_finished", finished, 1'b1);

    // Reset in the middle of a burst
    @(negedge clk);
    enable = 1'b1; valid_in = 1'b1; data_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && seen < 9; i++) begin
      @(negedge clk);
      if (valid_out) seen++;
    end
    chk("mid_reached", seen, 9);
    #2 reset = 1'b0;
    #1;
    chk("mid_valid_out", valid_out, 1'b0);
    chk("mid_finished", finished, 1'b1);
    chk("mid_data_out", data_out, 1'b0);
    chk("mid_ready", ready, 1'b1);
    @(negedge clk);
    valid_in = 1'b0; enable = 1'b0; data_in = 1'b0;
    reset = 1'b1;
    run_frame(64'h1, 1, 0, 0, got, cnt, lat, rdy_hi, fin_ok, done);
    chk("post_rst_done", done, 1'b1);
    chk("post_rst_len", cnt, 14);
    chk("post_rst_bits", got, pat("11011111001011"));

    // TAIL_BITS=0 build
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_frame(64'b101, 3, 0, 1, got, cnt, lat, rdy_hi, fin_ok, done);
    chk("t0_done", done, 1'b1);
    chk("t0_len", cnt, 6);
    chk("t0_bits", got, pat("110100"));
    chk("t0_finished", fin_ok, 1'b1);
    chk("t0_latency", lat, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
